dff_pair_monitor: RTL and testbench
===================================

# dff_pair_monitor

Single-clock event monitor that sits directly downstream of the two-clock OR/DFF block. It consumes that block's two registered outputs: `i1` from the `clk` domain and `i2` from a foreign domain. It synchronises `i2`, detects rising edges on both inputs, and keeps saturating per-input event counts. A small state machine reports whether an `i1` edge is followed by an `i2` edge within a programmable window.

## Interface
Parameters:
- `WIDTH`, 8: bit width of each event counter; legal range 1..32.
- `WINDOW`, 16: number of cycles after an `i1` edge during which an `i2` edge counts as a match; legal range 1..255.
- `SYNC_STAGES`, 2: number of flops in the `i2` synchroniser; legal range 2..4.

Ports:
- `clk` input 1: the only clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `i1` input 1: level from the upstream `clk`-domain register. Already synchronous.
- `i2` input 1: level from the upstream register in another clock domain. Asynchronous to `clk`.
- `clr` input 1: synchronous clear of `cnt1` and `cnt2` only.
- `cnt1` output WIDTH: count of `i1` rising edges, saturating.
- `cnt2` output WIDTH: count of `i2` rising edges, saturating.
- `armed` output 1: high while the FSM is in ARMED.
- `match` output 1: registered one-cycle pulse when a match is detected.
- `timeout` output 1: registered one-cycle pulse when the window expires.

## Operation
Input sampling:
- `i1` is sampled into `s1`. The previous value of `s1` is held in `p1`.
- Edge strobe `e1 = s1 & ~p1`.
- `i2` passes through a SYNC_STAGES-deep flop chain to give `s2`. The previous value of `s2` is held in `p2`.
- Edge strobe `e2 = s2 & ~p2`.

Counters:
- On `e1`, `cnt1` increments by 1. It holds at 2^WIDTH-1 and never wraps.
- `cnt2` behaves the same on `e2`.
- When `clr` is asserted, both counters load 0 that cycle. `clr` takes priority over an increment in the same cycle.
- `clr` does not affect the FSM, the synchroniser or the edge detectors.

FSM states: IDLE and ARMED. The window timer `t` is ceil(log2(WINDOW+1)) bits wide.
- IDLE with `e1`: go to ARMED, `t` = 0. An `e2` in the same cycle is ignored (no match).
- IDLE with no `e1`: stay in IDLE. A lone `e2` counts in `cnt2` only.
- ARMED with `e2`: `match` = 1 next cycle and go to IDLE. This has the highest priority, including when `e1` is also present.
- ARMED with `e1` and no `e2`: re-arm, `t` = 0, stay ARMED.
- ARMED with `t == WINDOW-1` and no `e1`/`e2`: `timeout` = 1 next cycle and go to IDLE.
- ARMED otherwise: `t` = `t` + 1.

Outputs:
- `armed` is decoded directly from the state register.
- `match` and `timeout` are registered, and are never high in the same cycle.

Reset:
- While `rst` is high at a posedge, all flops load 0.
- This covers the synchroniser, `s1`/`p1`/`s2`/`p2`, the counters, `t`, `match` and `timeout`. The state loads IDLE.
- Reset mid-window abandons the pending match silently; no `timeout` pulse is produced.
- `rst` takes priority over `clr` and over all events.
- Because `p` and `s` both reset to 0, an input that is already high after reset produces exactly one edge.

## Timing
- All outputs read 0 in the cycle after any reset edge.
- `i1` latency, with `i1` going high before posedge k:
  - `s1` = 1 after edge k, so `e1` is high in cycle k.
  - `cnt1` updates after edge k+1.
  - `armed` rises after edge k+1.
- `i2` latency, with `i2` going high before posedge k:
  - `s2` = 1 after edge k+SYNC_STAGES-1.
  - `cnt2` updates after edge k+SYNC_STAGES.
  - `match` is high for the single cycle following edge k+SYNC_STAGES.
- Window: an `i2` edge is a match if `e2` occurs within WINDOW cycles after the ARMED entry. `e2` in the cycle of entry+WINDOW is too late.
- `timeout` pulses in the cycle after the last window cycle, and `armed` falls at the same edge.
- Inputs held high generate no further edges. Back-to-back events need the input to go low for at least 1 cycle (i1) or 1 synchronised cycle (i2).

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `i1`=`i2`=1. Release. Then:
  - all outputs are 0 in the first cycle after the reset edge;
  - `cnt1`=1 one cycle later, and `cnt2`=1 SYNC_STAGES cycles after release;
  - no further increments while the inputs stay high.
- Match: WINDOW=16, SYNC_STAGES=2. Pulse `i1` at cycle 10 and `i2` at cycle 15.
  - `armed` goes 1 at cycle 12.
  - `match` is a single pulse at cycle 18, and `armed` goes 0 at the same edge.
  - `cnt1`=1, `cnt2`=1, `timeout` never asserted.
- Timeout: pulse `i1` only.
  - `armed` stays high for exactly 16 cycles.
  - `timeout` pulses once when `armed` falls.
  - A late `i2` afterwards increments `cnt2` only, with no `match`.
- Saturation and clear: WIDTH=3.
  - Apply 10 `i1` pulses: `cnt1` stops at 7.
  - Assert `clr` in the same cycle as an `e1`: `cnt1`=0 next cycle.
- Simultaneous events:
  - `i1` and `i2` edges with matching synchronised timing in IDLE: result is ARMED and no match.
  - `e1` and `e2` together while ARMED: `match`=1 and return to IDLE.
  - `e1` alone while ARMED: window restarts, `timeout` delayed a full WINDOW.
- Reset mid-window: arm, then assert `rst` 5 cycles later.
  - `armed`=0 after the reset edge.
  - Neither `timeout` nor `match` pulses at any time afterwards without new stimulus.

Source files
------------

// File: rtl/dff_pair_monitor_if.sv
// rtl/dff_pair_monitor_if.sv - Event inputs and monitor outputs of dff_pair_monitor
interface dff_pair_monitor_if #(
    parameter int WIDTH = 8
);
    logic             i1;
    logic             i2;
    logic             clr;
    logic [WIDTH-1:0] cnt1;
    logic [WIDTH-1:0] cnt2;
    logic             armed;
    logic             match;
    logic             timeout;

    modport master (
        output i1, i2, clr,
        input  cnt1, cnt2, armed, match, timeout
    );

    modport slave (
        input  i1, i2, clr,
        output cnt1, cnt2, armed, match, timeout
    );
endinterface

// File: rtl/dff_pair_monitor.sv
// rtl/dff_pair_monitor.sv - Edge counters and i1-then-i2 match window monitor
module dff_pair_monitor #(
    parameter int WIDTH       = 8,
    parameter int WINDOW      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dff_pair_monitor_if.slave bus
);
    localparam int            TW     = $clog2(WINDOW + 1);
    localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s1;
    logic                   p1;
    logic                   s2;
    logic                   p2;
    logic                   e1;
    logic                   e2;
    logic [WIDTH-1:0]       cnt1;
    logic [WIDTH-1:0]       cnt2;
    state_t                 state;
    state_t                 state_next;
    logic [TW-1:0]          t;
    logic [TW-1:0]          t_next;
    logic                   match;
    logic                   match_next;
    logic                   timeout;
    logic                   timeout_next;

    // i2 comes from a foreign clock domain; only the last sync stage is used
    assign s2 = sync[SYNC_STAGES-1];
    assign e1 = s1 & ~p1;
    assign e2 = s2 & ~p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            s1   <= 1'b0;
            p1   <= 1'b0;
            p2   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.i2};
            s1   <= bus.i1;
            p1   <= s1;
            p2   <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (e1 && (cnt1 != '1)) begin
                cnt1 <= cnt1 + WIDTH'(1);
            end
            if (e2 && (cnt2 != '1)) begin
                cnt2 <= cnt2 + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            t       <= '0;
            match   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            t       <= t_next;
            match   <= match_next;
            timeout <= timeout_next;
        end
    end

    // e2 wins over a simultaneous e1 while armed; a re-arm suppresses timeout
    always_comb begin
        state_next   = state;
        t_next       = t;
        match_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (e1) begin
                    state_next = ARMED;
                    t_next     = '0;
                end
            end
            ARMED: begin
                if (e2) begin
                    match_next = 1'b1;
                    state_next = IDLE;
                    t_next     = '0;
                end else if (e1) begin
                    t_next = '0;
                end else if (t == T_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                    t_next       = '0;
                end else begin
                    t_next = t + TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                t_next     = '0;
            end
        endcase
    end

    assign bus.cnt1    = cnt1;
    assign bus.cnt2    = cnt2;
    assign bus.armed   = (state == ARMED);
    assign bus.match   = match;
    assign bus.timeout = timeout;
endmodule

// File: tb/tb_dff_pair_monitor.sv
// tb/tb_dff_pair_monitor.sv - Self-checking bench for dff_pair_monitor
module tb_dff_pair_monitor;
    localparam int WINDOW = 16;
    localparam int SYNC   = 2;
    localparam int MAX_A  = 255;
    localparam int MAX_B  = 7;
    localparam int NVEC   = 19;

    logic clk = 1'b0;
    logic rst;
    logic i1;
    logic i2;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dff_pair_monitor_if #(.WIDTH(8)) bus_a ();
    dff_pair_monitor_if #(.WIDTH(3)) bus_b ();

    assign bus_a.i1  = i1;
    assign bus_a.i2  = i2;
    assign bus_a.clr = clr;
    assign bus_b.i1  = i1;
    assign bus_b.i2  = i2;
    assign bus_b.clr = clr;

    dff_pair_monitor #(.WIDTH(8), .WINDOW(WINDOW), .SYNC_STAGES(SYNC)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dff_pair_monitor #(.WIDTH(3), .WINDOW(WINDOW), .SYNC_STAGES(SYNC)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: input sample history plus the index of the last cycle
    // in which an i2 edge may still complete a match.
    int   q1[$];
    int   q2[$];
    int   m_c1a, m_c2a, m_c1b, m_c2b;
    int   win_last = -1;
    int   cyc = 0;
    logic m_armed, m_match, m_timeout;
    bit   model_on = 1'b0;

    task automatic model_step();
        bit e1, e2, in_win;
        if (rst) begin
            q1 = {};
            q2 = {};
            repeat (2) q1.push_back(0);
            repeat (SYNC + 1) q2.push_back(0);
            m_c1a = 0; m_c2a = 0; m_c1b = 0; m_c2b = 0;
            win_last  = -1;
            m_armed   = 1'b0;
            m_match   = 1'b0;
            m_timeout = 1'b0;
            model_on  = 1'b1;
        end else if (model_on) begin
            e1 = (q1[1] == 1) && (q1[0] == 0);
            e2 = (q2[1] == 1) && (q2[0] == 0);
            q1.push_back(int'(i1));
            void'(q1.pop_front());
            q2.push_back(int'(i2));
            void'(q2.pop_front());
            if (clr) begin
                m_c1a = 0; m_c2a = 0; m_c1b = 0; m_c2b = 0;
            end else begin
                if (e1) begin
                    m_c1a = (m_c1a < MAX_A) ? m_c1a + 1 : MAX_A;
                    m_c1b = (m_c1b < MAX_B) ? m_c1b + 1 : MAX_B;
                end
                if (e2) begin
                    m_c2a = (m_c2a < MAX_A) ? m_c2a + 1 : MAX_A;
                    m_c2b = (m_c2b < MAX_B) ? m_c2b + 1 : MAX_B;
                end
            end
            in_win    = (win_last >= cyc);
            m_match   = 1'b0;
            m_timeout = 1'b0;
            if (in_win && e2) begin
                m_match  = 1'b1;
                win_last = -1;
            end else if (e1) begin
                win_last = cyc + WINDOW;
            end else if (in_win && (cyc == win_last)) begin
                m_timeout = 1'b1;
                win_last  = -1;
            end
            m_armed = (win_last > cyc);
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("model_cnt1_w8", bus_a.cnt1, m_c1a);
            check("model_cnt2_w8", bus_a.cnt2, m_c2a);
            check("model_cnt1_w3", bus_b.cnt1, m_c1b);
            check("model_cnt2_w3", bus_b.cnt2, m_c2b);
            check("model_armed", bus_a.armed, m_armed);
            check("model_match", bus_a.match, m_match);
            check("model_timeout", bus_a.timeout, m_timeout);
            check("model_armed_w3", bus_b.armed, m_armed);
            check("model_match_w3", bus_b.match, m_match);
            check("model_timeout_w3", bus_b.timeout, m_timeout);
        end
    end

    task automatic watch(input int cycles, input int pulse_at, output int n_arm,
                         output int n_match, output int n_to, output int n_to_fall);
        logic prev;
        n_arm = 0; n_match = 0; n_to = 0; n_to_fall = 0;
        prev = bus_a.armed;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (bus_a.armed) n_arm++;
            if (bus_a.match) n_match++;
            if (bus_a.timeout) begin
                n_to++;
                if (prev && !bus_a.armed) n_to_fall++;
            end
            prev = bus_a.armed;
            i1 = (j == pulse_at);
        end
    endtask

    typedef struct {
        int rst; int i1; int i2; int clr;
        int c1; int c2; int arm; int mat; int to;
    } vec_t;

    vec_t tbl[NVEC];
    int   n_arm, n_match, n_to, n_to_fall;

    initial begin
        tbl = '{
            '{1, 1, 1, 0,  0, 0, 0, 0, 0},
            '{1, 1, 1, 0,  0, 0, 0, 0, 0},
            '{0, 1, 1, 0,  0, 0, 0, 0, 0},
            '{0, 1, 1, 0,  1, 0, 1, 0, 0},
            '{0, 1, 1, 0,  1, 1, 0, 1, 0},
            '{0, 1, 1, 0,  1, 1, 0, 0, 0},
            '{0, 1, 1, 0,  1, 1, 0, 0, 0},
            '{0, 0, 0, 0,  1, 1, 0, 0, 0},
            '{0, 1, 0, 0,  1, 1, 0, 0, 0},
            '{0, 0, 0, 0,  2, 1, 1, 0, 0},
            '{0, 0, 1, 0,  2, 1, 1, 0, 0},
            '{0, 0, 0, 0,  2, 1, 1, 0, 0},
            '{0, 0, 0, 0,  2, 2, 0, 1, 0},
            '{0, 0, 0, 0,  2, 2, 0, 0, 0},
            '{0, 1, 0, 1,  0, 0, 0, 0, 0},
            '{0, 0, 0, 0,  1, 0, 1, 0, 0},
            '{0, 1, 0, 1,  0, 0, 1, 0, 0},
            '{0, 0, 0, 1,  0, 0, 1, 0, 0},
            '{0, 0, 0, 0,  0, 0, 1, 0, 0}
        };
        rst = 1'b1; i1 = 1'b0; i2 = 1'b0; clr = 1'b0;

        for (int r = 0; r < NVEC; r++) begin
            rst = (tbl[r].rst != 0);
            i1  = (tbl[r].i1 != 0);
            i2  = (tbl[r].i2 != 0);
            clr = (tbl[r].clr != 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_cnt1", r), bus_a.cnt1, tbl[r].c1);
            check($sformatf("vec%0d_cnt2", r), bus_a.cnt2, tbl[r].c2);
            check($sformatf("vec%0d_armed", r), bus_a.armed, tbl[r].arm);
            check($sformatf("vec%0d_match", r), bus_a.match, tbl[r].mat);
            check($sformatf("vec%0d_timeout", r), bus_a.timeout, tbl[r].to);
        end
        i1 = 1'b0; i2 = 1'b0; clr = 1'b0;
        watch(24, -1, n_arm, n_match, n_to, n_to_fall);

        // Lone i1: full window then timeout, then a late i2 must not match
        i1 = 1'b1;
        watch(30, -1, n_arm, n_match, n_to, n_to_fall);
        check("timeout_armed_len", n_arm, WINDOW);
        check("timeout_pulses", n_to, 1);
        check("timeout_at_fall", n_to_fall, 1);
        check("timeout_no_match", n_match, 0);
        i2 = 1'b1;
        watch(1, -1, n_arm, n_match, n_to, n_to_fall);
        i2 = 1'b0;
        watch(8, -1, n_arm, n_match, n_to, n_to_fall);
        check("late_i2_no_match", n_match, 0);
        check("late_i2_not_armed", n_arm, 0);

        // Coincident synchronised edges in IDLE, then again while ARMED
        i2 = 1'b1;
        @(negedge clk); i1 = 1'b1;
        @(negedge clk); i1 = 1'b0; i2 = 1'b0;
        @(negedge clk);
        check("idle_both_armed", bus_a.armed, 1);
        check("idle_both_no_match", bus_a.match, 0);
        i2 = 1'b1;
        @(negedge clk); i1 = 1'b1;
        @(negedge clk); i1 = 1'b0; i2 = 1'b0;
        @(negedge clk);
        check("armed_both_match", bus_a.match, 1);
        check("armed_both_idle", bus_a.armed, 0);

        // Re-arm 9 cycles into the window pushes the timeout out by a full window
        i1 = 1'b1;
        watch(40, 8, n_arm, n_match, n_to, n_to_fall);
        check("rearm_armed_len", n_arm, 9 + WINDOW);
        check("rearm_timeouts", n_to, 1);
        check("rearm_timeout_at_fall", n_to_fall, 1);
        check("rearm_no_match", n_match, 0);

        for (int k = 0; k < 10; k++) begin
            i1 = 1'b1;
            @(negedge clk); i1 = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
        check("sat_cnt1_w3", bus_b.cnt1, MAX_B);
        i1 = 1'b1;
        @(negedge clk); i1 = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        check("clr_over_e1_w8", bus_a.cnt1, 0);
        check("clr_over_e1_w3", bus_b.cnt1, 0);
        check("clr_cnt2_w3", bus_b.cnt2, 0);

        // Reset in the middle of a window abandons it silently
        i1 = 1'b1;
        @(negedge clk); i1 = 1'b0;
        @(negedge clk);
        check("midwin_armed", bus_a.armed, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midwin_rst_armed", bus_a.armed, 0);
        check("midwin_rst_cnt1", bus_a.cnt1, 0);
        watch(30, -1, n_arm, n_match, n_to, n_to_fall);
        check("midwin_no_timeout", n_to, 0);
        check("midwin_no_match", n_match, 0);
        check("midwin_no_armed", n_arm, 0);

        for (int k = 0; k < 3000; k++) begin
            i1  = ($urandom_range(0, 5) == 0);
            i2  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; i1 = 1'b0; i2 = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
